// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_xcvr transceiver: FSM encodings,
// frame-length clamping and parity computation.
package uart_pkg;

   localparam int         MAX_DATA_W     = 15;
   localparam logic [3:0] MIN_LEN        = 4'd5;
   localparam int         DEF_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2, RX_DONE, RX_BREAK
   } rx_state_t;

   function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
      if (len < MIN_LEN) return MIN_LEN;
      if (len > max_len) return max_len;
      return len;
   endfunction

   // Only the low len bits take part; odd parity is the inverted XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic [3:0] len, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < MAX_DATA_W; i++)
         if (4'(i) < len) p = p ^ data[i];
      return p;
   endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// Word-level handshake bundle of the transceiver, plus FSM state for observation.
interface uart_xcvr_if #(parameter int DATA_W = 8);
   import uart_pkg::*;

   // A word moves on a cycle where valid && ready are both high at the rising
   // clock edge; valid, once raised, holds with stable data until that cycle.
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;
   logic              rx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_parity_err;
   logic              rx_frame_err;
   logic              rx_overrun;
   tx_state_t         tx_state;
   rx_state_t         rx_state;

   modport master (
      output tx_valid, tx_data, rx_ready,
      input  tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err,
             rx_overrun, tx_state, rx_state
   );

   modport slave (
      input  tx_valid, tx_data, rx_ready,
      output tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err,
             rx_overrun, tx_state, rx_state
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick: one pulse every max(div,1) clocks.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   output logic             os_tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last;

   // >= rather than == so a divisor lowered mid-count wraps at once.
   assign last    = (div == '0) ? '0 : div - DIV_W'(1);
   assign os_tick = (cnt >= last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt <= '0;
      else if (os_tick) cnt <= '0;
      else              cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/uart_xcvr.sv
// Single-clock UART transceiver: shared tick generator, TX serializer and
// mid-bit-sampling RX deserializer with optional internal loopback.
module uart_xcvr
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [3:0]       cfg_len,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_odd,
   input  logic             cfg_stop2,
   input  logic             cfg_loopback,
   output logic             txd,
   input  logic             rxd,
   uart_xcvr_if.slave       bus
);

   localparam int              OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]      MAX_LEN = 4'(DATA_W);

   logic os_tick;

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .div     (cfg_div),
      .os_tick (os_tick)
   );

   tx_state_t         tx_state;
   logic              tx_line, tx_ready_q, tx_busy_q, tx_go;
   logic [OS_W-1:0]   tx_cnt;
   logic [3:0]        tx_idx, tx_len_q;
   logic [DATA_W-1:0] tx_shr;
   logic              tx_par_en_q, tx_par_q, tx_stop2_q;

   assign txd          = cfg_loopback ? 1'b1 : tx_line;
   assign bus.tx_ready = tx_ready_q;
   assign bus.tx_busy  = tx_busy_q;
   assign bus.tx_state = tx_state;

   // tx_go marks that the start bit is on the line; until then START waits
   // for the first tick after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;  tx_line <= 1'b1;  tx_ready_q <= 1'b1;  tx_busy_q <= 1'b0;
         tx_go <= 1'b0;  tx_cnt <= '0;  tx_idx <= '0;  tx_shr <= '0;  tx_len_q <= MIN_LEN;
         tx_par_en_q <= 1'b0;  tx_par_q <= 1'b0;  tx_stop2_q <= 1'b0;
      end else if (tx_state == TX_IDLE) begin
         if (bus.tx_valid && tx_ready_q) begin
            tx_shr      <= bus.tx_data;
            tx_len_q    <= clamp_len(cfg_len, MAX_LEN);
            tx_par_en_q <= cfg_parity_en;
            tx_par_q    <= calc_parity(MAX_DATA_W'(bus.tx_data), clamp_len(cfg_len, MAX_LEN),
                                       cfg_parity_odd);
            tx_stop2_q  <= cfg_stop2;
            tx_ready_q  <= 1'b0;
            tx_busy_q   <= 1'b1;
            tx_go       <= 1'b0;
            tx_state    <= TX_START;
         end
      end else if (os_tick) begin
         if (tx_state == TX_START && !tx_go) begin
            tx_go   <= 1'b1;
            tx_line <= 1'b0;
            tx_cnt  <= '0;
         end else if (tx_cnt != OS_LAST) begin
            tx_cnt <= tx_cnt + OS_W'(1);
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx_idx   <= '0;
                  tx_line  <= tx_shr[0];
                  tx_shr   <= tx_shr >> 1;
               end
               TX_DATA: begin
                  if (tx_idx == tx_len_q - 4'd1) begin
                     tx_state <= tx_par_en_q ? TX_PARITY : TX_STOP1;
                     tx_line  <= tx_par_en_q ? tx_par_q : 1'b1;
                  end else begin
                     tx_idx  <= tx_idx + 4'd1;
                     tx_line <= tx_shr[0];
                     tx_shr  <= tx_shr >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP1;
                  tx_line  <= 1'b1;
               end
               TX_STOP1: begin
                  if (tx_stop2_q) begin
                     tx_state <= TX_STOP2;
                  end else begin
                     tx_state   <= TX_IDLE;
                     tx_ready_q <= 1'b1;
                     tx_busy_q  <= 1'b0;
                  end
               end
               default: begin
                  tx_state   <= TX_IDLE;
                  tx_line    <= 1'b1;
                  tx_ready_q <= 1'b1;
                  tx_busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   logic [1:0] rx_sync;
   logic       rx_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_sync <= 2'b11;
      else     rx_sync <= {rx_sync[0], cfg_loopback ? tx_line : rxd};
   end
   assign rx_in = rx_sync[1];

   rx_state_t         rx_state;
   logic [OS_W-1:0]   rx_cnt;
   logic [3:0]        rx_idx, rx_len_q;
   logic [DATA_W-1:0] rx_shr, rx_data_q;
   logic              rx_par_bit, rx_ferr, rx_par_en_q, rx_par_odd_q, rx_stop2_q;
   logic              rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q, rx_hs;

   assign rx_hs             = rx_valid_q && bus.rx_ready;
   assign bus.rx_valid      = rx_valid_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_parity_err = rx_perr_q;
   assign bus.rx_frame_err  = rx_ferr_q;
   assign bus.rx_overrun    = rx_ovr_q;
   assign bus.rx_state      = rx_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;  rx_cnt <= '0;  rx_idx <= '0;  rx_shr <= '0;  rx_len_q <= MIN_LEN;
         rx_par_bit <= 1'b0;  rx_ferr <= 1'b0;  rx_par_en_q <= 1'b0;  rx_par_odd_q <= 1'b0;
         rx_stop2_q <= 1'b0;  rx_valid_q <= 1'b0;  rx_data_q <= '0;  rx_perr_q <= 1'b0;
         rx_ferr_q <= 1'b0;  rx_ovr_q <= 1'b0;
      end else begin
         if (rx_hs) begin
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
         end
         case (rx_state)
            RX_IDLE: begin
               if (os_tick && !rx_in) begin
                  rx_cnt       <= '0;
                  rx_shr       <= '0;
                  rx_ferr      <= 1'b0;
                  rx_par_bit   <= 1'b0;
                  rx_len_q     <= clamp_len(cfg_len, MAX_LEN);
                  rx_par_en_q  <= cfg_parity_en;
                  rx_par_odd_q <= cfg_parity_odd;
                  rx_stop2_q   <= cfg_stop2;
                  rx_state     <= RX_START;
               end
            end
            // A pending unread word wins over the new one unless it is taken this cycle.
            RX_DONE: begin
               if (!rx_valid_q || rx_hs) begin
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_shr;
                  rx_perr_q  <= rx_par_en_q &&
                                (rx_par_bit != calc_parity(MAX_DATA_W'(rx_shr), rx_len_q, rx_par_odd_q));
                  rx_ferr_q  <= rx_ferr;
               end else begin
                  rx_ovr_q <= 1'b1;
               end
               rx_state <= (rx_ferr && !rx_in) ? RX_BREAK : RX_IDLE;
            end
            RX_BREAK: if (rx_in) rx_state <= RX_IDLE;
            default: begin
               if (os_tick) begin
                  if (rx_state == RX_START && rx_cnt == OS_MID) begin
                     rx_cnt   <= '0;
                     rx_idx   <= '0;
                     rx_state <= rx_in ? RX_IDLE : RX_DATA;
                  end else if (rx_state == RX_START || rx_cnt != OS_LAST) begin
                     rx_cnt <= rx_cnt + OS_W'(1);
                  end else begin
                     rx_cnt <= '0;
                     case (rx_state)
                        RX_DATA: begin
                           rx_shr <= rx_shr | (DATA_W'(rx_in) << rx_idx);
                           if (rx_idx == rx_len_q - 4'd1)
                              rx_state <= rx_par_en_q ? RX_PARITY : RX_STOP1;
                           else
                              rx_idx <= rx_idx + 4'd1;
                        end
                        RX_PARITY: begin
                           rx_par_bit <= rx_in;
                           rx_state   <= RX_STOP1;
                        end
                        RX_STOP1: begin
                           rx_ferr  <= rx_ferr | !rx_in;
                           rx_state <= rx_stop2_q ? RX_STOP2 : RX_DONE;
                        end
                        RX_STOP2: begin
                           rx_ferr  <= rx_ferr | !rx_in;
                           rx_state <= RX_DONE;
                        end
                        default: rx_state <= RX_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: waveform timing, loopback vector table,
// external-line corner cases, overrun and asynchronous reset.
module tb_uart_xcvr;
   import uart_pkg::*;

   localparam int DATA_W  = 8;
   localparam int DIV_W   = 16;
   localparam int OS      = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [DIV_W-1:0] cfg_div;
   logic [3:0]       cfg_len;
   logic             cfg_parity_en, cfg_parity_odd, cfg_stop2, cfg_loopback;
   logic             txd, rxd;

   uart_xcvr_if #(.DATA_W(DATA_W)) bus ();

   uart_xcvr #(.DATA_W(DATA_W), .DIV_W(DIV_W), .OVERSAMPLE(OS)) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_div        (cfg_div),
      .cfg_len        (cfg_len),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop2      (cfg_stop2),
      .cfg_loopback   (cfg_loopback),
      .txd            (txd),
      .rxd            (rxd),
      .bus            (bus)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;
   int lb_txd_low = 0;
   logic [DATA_W+1:0] exp_q[$];
   logic [DATA_W+1:0] mon_exp;

   typedef struct {
      logic [3:0] len;
      logic       par_en;
      logic       par_odd;
      logic       stop2;
      logic [7:0] data;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: pop on every output handshake
   always @(negedge clk) begin
      if (!rst && cfg_loopback && txd !== 1'b1) lb_txd_low++;
      if (!rst && bus.rx_valid && bus.rx_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_unexpected: got word %0h, expected none", bus.rx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rx_word", 32'({bus.rx_data, bus.rx_parity_err, bus.rx_frame_err}), 32'(mon_exp));
         end
      end
   end

   function automatic logic par_model(input logic [7:0] d, input int len, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < len; i++) p = p ^ d[i];
      return p;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [3:0] len, input logic pe, input logic po, input logic s2);
      cfg_len = len;  cfg_parity_en = pe;  cfg_parity_odd = po;  cfg_stop2 = s2;
   endtask

   task automatic tx_send(input logic [7:0] d);
      int w;
      w = 0;
      while (!bus.tx_ready && w < 3000) begin
         tick(1);
         w++;
      end
      check("tx_ready_wait", 32'(bus.tx_ready), 32'(1));
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      tick(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_tx_idle();
      int w;
      w = 0;
      while (!bus.tx_ready && w < 3000) begin
         tick(1);
         w++;
      end
      check("tx_idle_wait", 32'(bus.tx_ready), 32'(1));
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         tick(1);
         w++;
      end
      check("sb_drain", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic rx_bit(input logic b, input int cyc);
      rxd = b;
      tick(cyc);
   endtask

   task automatic rx_frame(input logic [7:0] d, input int len, input logic pe,
                           input logic pbit, input logic sbit, input logic s2);
      rx_bit(1'b0, OS);
      for (int i = 0; i < len; i++) rx_bit(d[i], OS);
      if (pe) rx_bit(pbit, OS);
      rx_bit(sbit, OS);
      if (s2) rx_bit(sbit, OS);
      rxd = 1'b1;
      tick(2 * OS);
   endtask

   // Sends 8N1 'd' on the external line and checks mid-bit values and frame length.
   task automatic tx_waveform(input string tag, input logic [7:0] d, input int div);
      int w, cnt, bitc;
      logic [9:0] seen, want;
      bitc = OS * ((div == 0) ? 1 : div);
      tx_send(d);
      check({tag, "_ready_low"}, 32'(bus.tx_ready), 32'(0));
      check({tag, "_busy"}, 32'(bus.tx_busy), 32'(1));
      w = 0;
      while (txd !== 1'b0 && w < 100) begin
         tick(1);
         w++;
      end
      check({tag, "_start_seen"}, 32'(txd), 32'(0));
      cnt  = 0;
      seen = '1;
      while (!bus.tx_ready && cnt < 4000) begin
         if (cnt % bitc == bitc / 2 && cnt / bitc < 10) seen[cnt / bitc] = txd;
         tick(1);
         cnt++;
      end
      want = {1'b1, d, 1'b0};
      check({tag, "_frame_cycles"}, 32'(cnt), 32'(10 * bitc));
      check({tag, "_bits"}, 32'(seen), 32'(want));
      check({tag, "_busy_end"}, 32'(bus.tx_busy), 32'(0));
      check({tag, "_txd_idle"}, 32'(txd), 32'(1));
   endtask

   initial begin
      vecs[0] = '{4'd8,  1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
      vecs[1] = '{4'd7,  1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A};
      vecs[2] = '{4'd5,  1'b1, 1'b1, 1'b0, 8'hFF, 8'h1F};
      vecs[3] = '{4'd6,  1'b1, 1'b0, 1'b0, 8'hC3, 8'h03};
      vecs[4] = '{4'd8,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
      vecs[5] = '{4'd3,  1'b0, 1'b0, 1'b0, 8'hE7, 8'h07};
      vecs[6] = '{4'd12, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF};
      vecs[7] = '{4'd8,  1'b1, 1'b1, 1'b0, 8'h81, 8'h81};

      rst = 1'b1;
      cfg_div = 16'd1;  cfg_loopback = 1'b0;  rxd = 1'b1;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      bus.tx_valid = 1'b0;  bus.tx_data = '0;  bus.rx_ready = 1'b1;
      tick(3);
      check("rst_txd", 32'(txd), 32'(1));
      check("rst_tx_ready", 32'(bus.tx_ready), 32'(1));
      check("rst_tx_busy", 32'(bus.tx_busy), 32'(0));
      check("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
      check("rst_rx_data", 32'(bus.rx_data), 32'(0));
      check("rst_flags", 32'({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}), 32'(0));
      rst = 1'b0;
      tick(3);

      // waveform and frame length, including divisor 0 and 2
      tx_waveform("t1_div1", 8'hA5, 1);
      cfg_div = 16'd0;
      tx_waveform("t1_div0", 8'h3C, 0);
      cfg_div = 16'd2;
      tx_waveform("t1_div2", 8'hA5, 2);
      cfg_div = 16'd1;
      tick(20);

      // loopback vector table; cfg scrambled mid-frame to exercise the snapshots
      cfg_loopback = 1'b1;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         set_cfg(vecs[i].len, vecs[i].par_en, vecs[i].par_odd, vecs[i].stop2);
         exp_q.push_back({vecs[i].exp_data, 1'b0, 1'b0});
         tx_send(vecs[i].data);
         tick(40);
         set_cfg((vecs[i].len == 4'd8) ? 4'd5 : 4'd8, ~vecs[i].par_en, ~vecs[i].par_odd,
                 ~vecs[i].stop2);
         wait_tx_idle();
         wait_drain();
         tick(20);
      end
      check("lb_txd_high", 32'(lb_txd_low), 32'(0));
      cfg_loopback = 1'b0;
      tick(4);

      // external frames: wrong parity, good parity, bad stop bit
      set_cfg(4'd8, 1'b1, 1'b1, 1'b0);
      exp_q.push_back({8'h3C, 1'b1, 1'b0});
      rx_frame(8'h3C, 8, 1'b1, ~par_model(8'h3C, 8, 1'b1), 1'b1, 1'b0);
      wait_drain();
      exp_q.push_back({8'hC6, 1'b0, 1'b0});
      rx_frame(8'hC6, 8, 1'b1, par_model(8'hC6, 8, 1'b1), 1'b1, 1'b0);
      wait_drain();
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
      exp_q.push_back({8'h96, 1'b0, 1'b1});
      rx_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_drain();
      tick(20);

      // false start: 3-tick glitch
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(300);
      check("t4_no_valid", 32'(bus.rx_valid), 32'(0));
      check("t4_rx_idle", 32'(bus.rx_state), 32'(RX_IDLE));

      // line held low for two frames: one break word, then silence
      exp_q.push_back({8'h00, 1'b0, 1'b1});
      rxd = 1'b0;
      tick(2 * 10 * OS);
      check("t5_break_state", 32'(bus.rx_state), 32'(RX_BREAK));
      check("t5_one_word", 32'(exp_q.size()), 32'(0));
      rxd = 1'b1;
      tick(40);
      check("t5_idle", 32'(bus.rx_state), 32'(RX_IDLE));
      exp_q.push_back({8'h55, 1'b0, 1'b0});
      rx_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_drain();

      // overrun: two loopback words with the consumer stalled
      bus.rx_ready = 1'b0;
      cfg_loopback = 1'b1;
      tick(4);
      tx_send(8'h11);
      tx_send(8'h22);
      wait_tx_idle();
      tick(40);
      check("t6_valid", 32'(bus.rx_valid), 32'(1));
      check("t6_kept_data", 32'(bus.rx_data), 32'(8'h11));
      check("t6_overrun", 32'(bus.rx_overrun), 32'(1));
      exp_q.push_back({8'h11, 1'b0, 1'b0});
      bus.rx_ready = 1'b1;
      tick(1);
      check("t6_valid_clr", 32'(bus.rx_valid), 32'(0));
      check("t6_overrun_clr", 32'(bus.rx_overrun), 32'(0));
      check("t6_sb_empty", 32'(exp_q.size()), 32'(0));

      // asynchronous reset in the middle of a transmitted frame
      cfg_loopback = 1'b0;
      tick(4);
      tx_send(8'hF0);
      tick(50);
      check("t7_mid_txd", 32'(txd), 32'(0));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t7_txd", 32'(txd), 32'(1));
      check("t7_tx_ready", 32'(bus.tx_ready), 32'(1));
      check("t7_tx_busy", 32'(bus.tx_busy), 32'(0));
      check("t7_rx_out", 32'({bus.rx_valid, bus.rx_data}), 32'(0));
      check("t7_flags", 32'({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}), 32'(0));
      tick(2);
      rst = 1'b0;
      tick(5);
      check("t7_tx_state", 32'(bus.tx_state), 32'(TX_IDLE));
      check("t7_txd_after", 32'(txd), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
